// File: rtl/data_mem_arbiter_if.sv
// Requester/memory bundle for data_mem_arbiter: two requesters (A, B) on one side,
// a single-ported data memory on the other.
interface data_mem_arbiter_if;
  // req is held high until the matching gnt pulse; gnt marks the one ACCESS cycle,
  // and the requester drops or changes req on the clock edge that ends it.
  logic        a_req,    b_req;
  logic        a_we,     b_we;
  logic [15:0] a_addr,   b_addr;
  logic [15:0] a_wdata,  b_wdata;
  logic        a_size,   b_size;
  logic        a_memd,   b_memd;
  logic        a_gnt,    b_gnt;
  logic        a_rvalid, b_rvalid;
  logic [15:0] a_rdata,  b_rdata;

  logic        MemWrite, MemRead;
  logic [15:0] ReadAddr, WriteAddr, writeData;
  logic        MemSize,  MemD;
  logic [15:0] readData;

  modport slave (
    input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
           a_size, b_size, a_memd, b_memd, readData,
    output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
           MemWrite, MemRead, ReadAddr, WriteAddr, writeData, MemSize, MemD
  );

  modport master (
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
           a_size, b_size, a_memd, b_memd, readData,
    input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
           MemWrite, MemRead, ReadAddr, WriteAddr, writeData, MemSize, MemD
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester data memory arbiter with an IDLE/ACCESS/RESP sequencer.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to A.
module data_mem_arbiter (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_arbiter_if.slave    bus,
  output logic [1:0]           dbgState
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  logic   ownerB;
  logic   weLat;
  logic   pickB;

`ifdef ARB_ROUND_ROBIN_EN
  logic   lastB;

  // lastB resets to B so that A takes the first contended grant.
  always_comb begin
    pickB = 1'b0;
    if (bus.a_req && bus.b_req)
      pickB = !lastB;
    else
      pickB = bus.b_req;
  end
`else
  always_comb begin
    pickB = 1'b0;
    pickB = bus.b_req && !bus.a_req;
  end
`endif

  assign dbgState = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ownerB        <= 1'b0;
      weLat         <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      lastB         <= 1'b1;
`endif
      bus.a_gnt     <= 1'b0;
      bus.b_gnt     <= 1'b0;
      bus.a_rvalid  <= 1'b0;
      bus.b_rvalid  <= 1'b0;
      bus.a_rdata   <= 16'h0000;
      bus.b_rdata   <= 16'h0000;
      bus.MemWrite  <= 1'b0;
      bus.MemRead   <= 1'b0;
      bus.ReadAddr  <= 16'h0000;
      bus.WriteAddr <= 16'h0000;
      bus.writeData <= 16'h0000;
      bus.MemSize   <= 1'b0;
      bus.MemD      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.a_req || bus.b_req) begin
            state         <= ACCESS;
            ownerB        <= pickB;
            weLat         <= pickB ? bus.b_we : bus.a_we;
`ifdef ARB_ROUND_ROBIN_EN
            lastB         <= pickB;
`endif
            bus.a_gnt     <= !pickB;
            bus.b_gnt     <= pickB;
            bus.MemWrite  <= pickB ? bus.b_we : bus.a_we;
            bus.MemRead   <= pickB ? !bus.b_we : !bus.a_we;
            bus.ReadAddr  <= pickB ? bus.b_addr : bus.a_addr;
            bus.WriteAddr <= pickB ? bus.b_addr : bus.a_addr;
            bus.writeData <= pickB ? bus.b_wdata : bus.a_wdata;
            bus.MemSize   <= pickB ? bus.b_size : bus.a_size;
            bus.MemD      <= pickB ? bus.b_memd : bus.a_memd;
          end
        end
        ACCESS: begin
          bus.a_gnt    <= 1'b0;
          bus.b_gnt    <= 1'b0;
          bus.MemWrite <= 1'b0;
          bus.MemRead  <= 1'b0;
          if (weLat) begin
            state <= IDLE;
          end else begin
            // readData is only valid while MemRead is high, so capture it here.
            state <= RESP;
            if (ownerB) begin
              bus.b_rdata  <= bus.readData;
              bus.b_rvalid <= 1'b1;
            end else begin
              bus.a_rdata  <= bus.readData;
              bus.a_rvalid <= 1'b1;
            end
          end
        end
        RESP: begin
          state        <= IDLE;
          bus.a_rvalid <= 1'b0;
          bus.b_rvalid <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed transactions, a transaction-level occupancy
// model compared every cycle, and literal checks on the headline scenarios.
module tb_data_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbgState;
  int         tests = 0;
  int         fails = 0;

  data_mem_arbiter_if bus ();

  data_mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbgState (dbgState)
  );

  always #5 clk = ~clk;

  // Memory: combinational read while MemRead, write commits on the clock edge.
  logic [15:0] mem [256];
  assign bus.readData = bus.MemRead ? mem[bus.ReadAddr[7:0]] : 16'h0000;
  always @(posedge clk) if (bus.MemWrite) mem[bus.WriteAddr[7:0]] <= bus.writeData;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the arbiter is busy for 1 edge after a write grant and 2 after a read grant;
  // a read answers with the model memory's content one edge after its grant.
  bit          mGntA, mGntB, mWr, mRd, mRvA, mRvB, mSize, mMemd;
  logic [15:0] mAddr = 16'h0, mWdata = 16'h0, mRdA = 16'h0, mRdB = 16'h0;
  logic [15:0] modelMem [256];
  int          skip = 0;
  bit          rvDue, rvB, winB, we;
  logic [15:0] rvData = 16'h0, addr;
`ifdef ARB_ROUND_ROBIN_EN
  bit          lastB = 1'b1;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      {mGntA, mGntB, mWr, mRd, mRvA, mRvB, mSize, mMemd} = 8'h00;
      mAddr = 16'h0; mWdata = 16'h0; mRdA = 16'h0; mRdB = 16'h0;
      skip = 0; rvDue = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      lastB = 1'b1;
`endif
    end else begin
      {mGntA, mGntB, mWr, mRd, mRvA, mRvB} = 6'h00;
      if (rvDue) begin
        rvDue = 1'b0;
        if (rvB) begin mRvB = 1'b1; mRdB = rvData; end
        else     begin mRvA = 1'b1; mRdA = rvData; end
      end
      if (skip > 0) skip--;
      else if (bus.a_req || bus.b_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        winB  = (bus.a_req && bus.b_req) ? !lastB : bus.b_req;
        lastB = winB;
`else
        winB  = !bus.a_req;
`endif
        we     = winB ? bus.b_we : bus.a_we;
        addr   = winB ? bus.b_addr : bus.a_addr;
        mGntA  = !winB; mGntB = winB;
        mWr    = we;    mRd   = !we;
        mAddr  = addr;
        mWdata = winB ? bus.b_wdata : bus.a_wdata;
        mSize  = winB ? bus.b_size : bus.a_size;
        mMemd  = winB ? bus.b_memd : bus.a_memd;
        if (we) begin
          modelMem[addr[7:0]] = mWdata;
          skip = 1;
        end else begin
          rvDue = 1'b1; rvB = winB; rvData = modelMem[addr[7:0]];
          skip = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("gnt",       16'({bus.a_gnt, bus.b_gnt}),       16'({mGntA, mGntB}));
      check("strobes",   16'({bus.MemWrite, bus.MemRead}),  16'({mWr, mRd}));
      check("rvalid",    16'({bus.a_rvalid, bus.b_rvalid}), 16'({mRvA, mRvB}));
      check("a_rdata",   bus.a_rdata,   mRdA);
      check("b_rdata",   bus.b_rdata,   mRdB);
      check("ReadAddr",  bus.ReadAddr,  mAddr);
      check("WriteAddr", bus.WriteAddr, mAddr);
      check("writeData", bus.writeData, mWdata);
      check("attrs",     16'({bus.MemSize, bus.MemD}),      16'({mSize, mMemd}));
    end
  end

  task automatic wait_gnt(input bit isB, input string name);
    bit got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (isB ? bus.b_gnt : bus.a_gnt) begin got = 1'b1; break; end
    end
    check(name, 16'(got), 16'h0001);
  endtask

  // Raises one request, waits for its grant, drops it on the edge ending ACCESS.
  task automatic issue(input bit isB, input bit w, input logic [15:0] ad,
                       input logic [15:0] wd, input bit sz, input bit md);
    @(posedge clk); #1;
    if (isB) begin
      bus.b_req = 1'b1; bus.b_we = w; bus.b_addr = ad; bus.b_wdata = wd;
      bus.b_size = sz; bus.b_memd = md;
    end else begin
      bus.a_req = 1'b1; bus.a_we = w; bus.a_addr = ad; bus.a_wdata = wd;
      bus.a_size = sz; bus.a_memd = md;
    end
    wait_gnt(isB, isB ? "b_issue_gnt" : "a_issue_gnt");
    @(posedge clk); #1;
    if (isB) bus.b_req = 1'b0; else bus.a_req = 1'b0;
  endtask

  logic [3:0] seqBits, expSeq;
  int         nGnt;

  initial begin
    {bus.a_req, bus.b_req, bus.a_we, bus.b_we} = 4'h0;
    {bus.a_size, bus.b_size, bus.a_memd, bus.b_memd} = 4'h0;
    bus.a_addr = 16'h0; bus.b_addr = 16'h0; bus.a_wdata = 16'h0; bus.b_wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_strobes", 16'({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid,
                                bus.MemWrite, bus.MemRead, bus.MemSize, bus.MemD}), 16'h0000);
    check("reset_rdata", bus.a_rdata | bus.b_rdata, 16'h0000);
    check("reset_addr", bus.ReadAddr | bus.WriteAddr | bus.writeData, 16'h0000);

    // A writes ABCD to 0000, then reads it back.
    issue(1'b0, 1'b1, 16'h0000, 16'hABCD, 1'b0, 1'b0);
    check("a_wr_addr", bus.WriteAddr, 16'h0000);
    check("a_wr_data", bus.writeData, 16'hABCD);
    issue(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    check("a_rd_rvalid", 16'(bus.a_rvalid), 16'h0001);
    check("a_rd_data", bus.a_rdata, 16'hABCD);
    check("a_rd_b_untouched", bus.b_rdata, 16'h0000);

    // B writes CFCF with size/memd set, then reads it back.
    issue(1'b1, 1'b1, 16'h0010, 16'hCFCF, 1'b1, 1'b1);
    check("b_wr_attrs", 16'({bus.MemSize, bus.MemD}), 16'h0003);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    check("b_rd_rvalid", 16'(bus.b_rvalid), 16'h0001);
    check("b_rd_data", bus.b_rdata, 16'hCFCF);
    check("b_rd_a_untouched", bus.a_rdata, 16'hABCD);

    // Both requesters hold reads continuously.
    @(posedge clk); #1;
    bus.a_we = 1'b0; bus.a_addr = 16'h0000; bus.a_size = 1'b0; bus.a_memd = 1'b0;
    bus.b_we = 1'b0; bus.b_addr = 16'h0010; bus.b_size = 1'b0; bus.b_memd = 1'b0;
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    seqBits = 4'h0; nGnt = 0;
    for (int n = 0; n < 60 && nGnt < 4; n++) begin
      @(negedge clk);
      if (bus.a_gnt || bus.b_gnt) begin
        seqBits[nGnt] = bus.b_gnt;
        nGnt++;
      end
    end
    @(posedge clk); #1;
    bus.a_req = 1'b0; bus.b_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    expSeq = 4'b1010;
`else
    expSeq = 4'b0000;
`endif
    check("contend_count", 16'(nGnt), 16'd4);
    check("contend_seq", 16'(seqBits), 16'(expSeq));
    repeat (3) @(posedge clk);

    // 3 ns reset pulse in the middle of an A read.
    #1;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h0010;
    wait_gnt(1'b0, "abort_gnt");
    #1 rst = 1'b1; bus.a_req = 1'b0;
    #1;
    check("abort_memread", 16'({bus.MemRead, bus.MemWrite, bus.a_gnt}), 16'h0000);
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_rvalid", 16'({bus.a_rvalid, bus.b_rvalid, bus.a_gnt}), 16'h0000);
    end
    check("abort_rdata_cleared", bus.a_rdata, 16'h0000);

    // First contended grant after reset goes to A.
    @(posedge clk); #1;
    bus.a_req = 1'b1; bus.b_req = 1'b1; bus.b_addr = 16'h0000;
    wait_gnt(1'b0, "post_reset_a_first");
    @(posedge clk); #1 bus.a_req = 1'b0;
    wait_gnt(1'b1, "post_reset_b_next");
    @(posedge clk); #1 bus.b_req = 1'b0;
    @(negedge clk);
    check("post_reset_b_data", bus.b_rdata, 16'hABCD);
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
